// File: rtl/round_key_store_pkg.sv
// Shared constants and types for the round-key store.
// Optional double buffering is enabled with ROUND_KEY_STORE_DBUF_EN.
package round_key_store_pkg;

  localparam int unsigned AES128_ROUNDS         = 10;
  localparam int unsigned AES256_ROUNDS         = 14;
  localparam int unsigned ROUND_KEY_STORE_DEPTH = 15;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } bank_state_e;

  // Anything that is not AES-128 is handled as the AES-256 worst case.
  function automatic logic [3:0] norm_rounds(input logic [3:0] rt);
    return (rt == 4'(AES128_ROUNDS)) ? 4'(AES128_ROUNDS) : 4'(AES256_ROUNDS);
  endfunction

endpackage

// File: rtl/round_key_store_if.sv
// Bus between key expansion / round core and the round-key store.
interface round_key_store_if #(
  parameter int unsigned KEY_BITS  = 128,
  parameter int unsigned ADDR_BITS = 4
);
  logic                 exp_start;
  logic [3:0]           rounds_total;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [KEY_BITS-1:0]  wr_data;
  logic                 wr_done;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 decrypt;
  logic [KEY_BITS-1:0]  rd_data;
  logic                 rd_valid;
  logic                 rd_err;
  logic                 load_err;
  logic                 keys_ready;

  modport master (
    output exp_start, rounds_total, wr_en, wr_addr, wr_data, wr_done,
           rd_en, rd_addr, decrypt,
    input  rd_data, rd_valid, rd_err, load_err, keys_ready
  );

  modport slave (
    input  exp_start, rounds_total, wr_en, wr_addr, wr_data, wr_done,
           rd_en, rd_addr, decrypt,
    output rd_data, rd_valid, rd_err, load_err, keys_ready
  );
endinterface

// File: rtl/round_key_store_bank.sv
// One round-key bank: key memory, load FSM, write counter and latched round count.
module round_key_bank
  import round_key_store_pkg::*;
#(
  parameter int unsigned KEY_BITS  = 128,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DEPTH     = ROUND_KEY_STORE_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exp_start_i,
  input  logic [3:0]           rounds_total_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [KEY_BITS-1:0]  wr_data_i,
  input  logic                 wr_done_i,
  input  logic                 clr_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [KEY_BITS-1:0]  rd_data_o,
  output logic                 ready_o,
  output logic [ADDR_BITS-1:0] rounds_o,
  output logic                 done_ok_o,
  output logic                 load_err_o
);

  bank_state_e          state_q;
  logic [ADDR_BITS-1:0] cnt_q;
  logic [ADDR_BITS-1:0] rounds_q;
  logic                 load_err_q;
  logic [KEY_BITS-1:0]  mem_q [DEPTH];

  logic loading, done_ok, wr_ok, wr_bad;

  // exp_start restarts the load, so a write in that same cycle is discarded.
  always_comb begin
    loading = (state_q == ST_LOADING) && !exp_start_i;
    done_ok = loading && wr_done_i && (cnt_q == rounds_q + 1'b1);
    wr_ok   = loading && !wr_done_i && wr_en_i && (wr_addr_i <= rounds_q);
    wr_bad  = loading && !wr_done_i && wr_en_i && (wr_addr_i > rounds_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      cnt_q      <= '0;
      rounds_q   <= '0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      if (clr_i) begin
        state_q <= ST_EMPTY;
      end else if (exp_start_i) begin
        state_q  <= ST_LOADING;
        rounds_q <= ADDR_BITS'(norm_rounds(rounds_total_i));
        cnt_q    <= '0;
      end else if (state_q == ST_LOADING) begin
        if (wr_done_i) begin
          state_q    <= done_ok ? ST_READY : ST_EMPTY;
          load_err_q <= !done_ok;
        end else if (wr_bad) begin
          load_err_q <= 1'b1;
        end else if (wr_ok && cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o  = (rd_addr_i < ADDR_BITS'(DEPTH)) ? mem_q[rd_addr_i] : '0;
  assign ready_o    = (state_q == ST_READY);
  assign rounds_o   = rounds_q;
  assign done_ok_o  = done_ok;
  assign load_err_o = load_err_q;

endmodule

// File: rtl/round_key_store.sv
// Round-key store: captures the expanded key schedule and serves it via a registered read port.
// Define ROUND_KEY_STORE_DBUF_EN for two banks so a new key loads while the current one is read.
module round_key_store
  import round_key_store_pkg::*;
#(
  parameter int unsigned KEY_BITS  = 128,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DEPTH     = ROUND_KEY_STORE_DEPTH
) (
  input logic              clk,
  input logic              reset_n,
  round_key_store_if.slave bus
);

  logic [ADDR_BITS-1:0] act_rounds;
  logic [ADDR_BITS-1:0] phys_addr;
  logic [KEY_BITS-1:0]  act_key;
  logic                 act_ready;
  logic                 rd_ok;
  logic [KEY_BITS-1:0]  rd_data_q;
  logic                 rd_valid_q;
  logic                 rd_err_q;

`ifdef ROUND_KEY_STORE_DBUF_EN
  logic                 act_sel_q;
  logic                 swap;
  logic [1:0]           b_ready, b_done, b_lerr;
  logic [ADDR_BITS-1:0] b_rounds [2];
  logic [KEY_BITS-1:0]  b_key [2];

  // Only the load bank sees load traffic, so any done_ok means "swap now".
  assign swap = |b_done;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    localparam logic BANK_ID = 1'(g);
    logic is_load;
    assign is_load = (act_sel_q != BANK_ID);

    round_key_bank #(
      .KEY_BITS (KEY_BITS),
      .ADDR_BITS(ADDR_BITS),
      .DEPTH    (DEPTH)
    ) u_bank (
      .clk           (clk),
      .rst_n         (reset_n),
      .exp_start_i   (bus.exp_start & is_load),
      .rounds_total_i(bus.rounds_total),
      .wr_en_i       (bus.wr_en & is_load),
      .wr_addr_i     (bus.wr_addr),
      .wr_data_i     (bus.wr_data),
      .wr_done_i     (bus.wr_done & is_load),
      .clr_i         (swap & !is_load),
      .rd_addr_i     (phys_addr),
      .rd_data_o     (b_key[g]),
      .ready_o       (b_ready[g]),
      .rounds_o      (b_rounds[g]),
      .done_ok_o     (b_done[g]),
      .load_err_o    (b_lerr[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  act_sel_q <= 1'b0;
    else if (swap) act_sel_q <= ~act_sel_q;
  end

  assign act_ready    = b_ready[act_sel_q];
  assign act_rounds   = b_rounds[act_sel_q];
  assign act_key      = b_key[act_sel_q];
  assign bus.load_err = |b_lerr;
`else
  logic unused_done;

  round_key_bank #(
    .KEY_BITS (KEY_BITS),
    .ADDR_BITS(ADDR_BITS),
    .DEPTH    (DEPTH)
  ) u_bank (
    .clk           (clk),
    .rst_n         (reset_n),
    .exp_start_i   (bus.exp_start),
    .rounds_total_i(bus.rounds_total),
    .wr_en_i       (bus.wr_en),
    .wr_addr_i     (bus.wr_addr),
    .wr_data_i     (bus.wr_data),
    .wr_done_i     (bus.wr_done),
    .clr_i         (1'b0),
    .rd_addr_i     (phys_addr),
    .rd_data_o     (act_key),
    .ready_o       (act_ready),
    .rounds_o      (act_rounds),
    .done_ok_o     (unused_done),
    .load_err_o    (bus.load_err)
  );
`endif

  // Reads are judged against the pre-edge state, so a read alongside exp_start is still served.
  assign phys_addr = bus.decrypt ? (act_rounds - bus.rd_addr) : bus.rd_addr;
  assign rd_ok     = act_ready && (bus.rd_addr <= act_rounds);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en && rd_ok;
      rd_err_q   <= bus.rd_en && !rd_ok;
      if (bus.rd_en && rd_ok) rd_data_q <= act_key;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.keys_ready = act_ready;

endmodule

// File: tb/tb_round_key_store.sv
// Self-checking bench for round_key_store: directed vector table, reset sequence and
// randomized load/read episodes against a behavioural schedule model.
`timescale 1ns/1ps
module tb_round_key_store;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  round_key_store_if #(.KEY_BITS(128), .ADDR_BITS(4)) bus ();

  round_key_store #(.KEY_BITS(128), .ADDR_BITS(4), .DEPTH(15)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_tests;
  int n_fail;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] k128(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {16{b}};
  endfunction

  function automatic logic [127:0] k256(input int i);
    logic [7:0] b;
    b = 8'(i) | 8'h80;
    return {16{b}};
  endfunction

  function automatic logic [127:0] kalt(input int i);
    logic [7:0] b;
    b = 8'(i) | 8'hC0;
    return {16{b}};
  endfunction

  task automatic idle();
    bus.exp_start    = 1'b0;
    bus.rounds_total = '0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.wr_done      = 1'b0;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = '0;
    bus.decrypt      = 1'b0;
  endtask

  // Behavioural model: a table of stored keys plus "is a full schedule held" bookkeeping.
  logic [127:0] m_key [15];
  int           m_phase;   // 0 nothing usable, 1 loading, 2 complete schedule
  int           m_rounds;
  int           m_cnt;
  logic [127:0] m_rd_data;
  logic         m_rd_valid, m_rd_err, m_load_err;

  function automatic void model_reset();
    m_phase = 0; m_rounds = 0; m_cnt = 0;
    m_rd_data = '0; m_rd_valid = 1'b0; m_rd_err = 1'b0; m_load_err = 1'b0;
  endfunction

  function automatic void model_step();
    int ra;
    ra = int'(bus.rd_addr);
    m_rd_valid = 1'b0;
    m_rd_err   = 1'b0;
    if (bus.rd_en) begin
      if (m_phase == 2 && ra <= m_rounds) begin
        m_rd_valid = 1'b1;
        m_rd_data  = m_key[bus.decrypt ? m_rounds - ra : ra];
      end else begin
        m_rd_err = 1'b1;
      end
    end
    m_load_err = 1'b0;
    if (bus.exp_start) begin
      m_phase  = 1;
      m_rounds = (bus.rounds_total == 4'd10) ? 10 : 14;
      m_cnt    = 0;
    end else if (m_phase == 1) begin
      if (bus.wr_done) begin
        if (m_cnt == m_rounds + 1) m_phase = 2;
        else begin m_phase = 0; m_load_err = 1'b1; end
      end else if (bus.wr_en) begin
        if (int'(bus.wr_addr) > m_rounds) m_load_err = 1'b1;
        else begin
          m_key[bus.wr_addr] = bus.wr_data;
          m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        end
      end
    end
  endfunction

  task automatic tick_raw();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    #1;
    chk({name, "/m_data"},  bus.rd_data,           m_rd_data);
    chk({name, "/m_valid"}, 128'(bus.rd_valid),    128'(m_rd_valid));
    chk({name, "/m_err"},   128'(bus.rd_err),      128'(m_rd_err));
    chk({name, "/m_lerr"},  128'(bus.load_err),    128'(m_load_err));
    chk({name, "/m_ready"}, 128'(bus.keys_ready),  128'(m_phase == 2));
  endtask

  task automatic chk_outs(input string name, input logic [127:0] d, input logic v, input logic e,
                          input logic l, input logic r);
    chk({name, "/data"},  bus.rd_data,          d);
    chk({name, "/valid"}, 128'(bus.rd_valid),   128'(v));
    chk({name, "/err"},   128'(bus.rd_err),     128'(e));
    chk({name, "/lerr"},  128'(bus.load_err),   128'(l));
    chk({name, "/ready"}, 128'(bus.keys_ready), 128'(r));
  endtask

  typedef struct {
    string        nm;
    logic         es;  logic [3:0] rt;
    logic         we;  logic [3:0] wa; logic [127:0] wd; logic wdn;
    logic         re;  logic [3:0] ra; logic dec;
    logic         ev, ee, el, er;
    logic [127:0] ed;
  } vec_t;

  vec_t         tbl[$];
  logic [127:0] last_d;

  function automatic void add(input string nm, input logic es, input logic [3:0] rt,
                              input logic we, input logic [3:0] wa, input logic [127:0] wd,
                              input logic wdn, input logic re, input logic [3:0] ra,
                              input logic dec, input logic ev, input logic ee, input logic el,
                              input logic er, input logic [127:0] ed);
    vec_t v;
    v.nm = nm; v.es = es; v.rt = rt; v.we = we; v.wa = wa; v.wd = wd; v.wdn = wdn;
    v.re = re; v.ra = ra; v.dec = dec; v.ev = ev; v.ee = ee; v.el = el; v.er = er;
    if (ev) last_d = ed;
    v.ed = last_d;
    tbl.push_back(v);
  endfunction

  task automatic build_table();
    last_d = '0;
    add("idle",       0, 0, 0, 0, '0, 0, 0, 0, 0,  0, 0, 0, 0, '0);
    add("start256",   1, 14, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 15; i++)
      add("wr256",    0, 0, 1, 4'(i), k256(i), 0, 0, 0, 0, 0, 0, 0, 0, '0);
    add("done256",    0, 0, 0, 0, '0, 1, 0, 0, 0,  0, 0, 0, 1, '0);
    add("dec_a0",     0, 0, 0, 0, '0, 0, 1, 0, 1,  1, 0, 0, 1, k256(14));
    add("dec_a14",    0, 0, 0, 0, '0, 0, 1, 14, 1, 1, 0, 0, 1, k256(0));
    add("enc_a5",     0, 0, 0, 0, '0, 0, 1, 5, 0,  1, 0, 0, 1, k256(5));
    add("wr_ready",   0, 0, 1, 5, '1, 0, 0, 0, 0,  0, 0, 0, 1, '0);
    add("enc_a5_old", 0, 0, 0, 0, '0, 0, 1, 5, 0,  1, 0, 0, 1, k256(5));
    add("start128_rd",1, 10, 0, 0, '0, 0, 1, 2, 0, 1, 0, 0, 0, k256(2));
    for (int i = 0; i < 11; i++) begin
      if (i == 6) add("wr_oob11", 0, 0, 1, 11, '1, 0, 0, 0, 0, 0, 0, 1, 0, '0);
      add("wr128",    0, 0, 1, 4'(i), k128(i), 0, 0, 0, 0, 0, 0, 0, 0, '0);
    end
    add("done128",    0, 0, 0, 0, '0, 1, 0, 0, 0,  0, 0, 0, 1, '0);
    add("rd3",        0, 0, 0, 0, '0, 0, 1, 3, 0,  1, 0, 0, 1, k128(3));
    add("rd12_rej",   0, 0, 0, 0, '0, 0, 1, 12, 0, 0, 1, 0, 1, '0);
    add("rd11_rej",   0, 0, 0, 0, '0, 0, 1, 11, 0, 0, 1, 0, 1, '0);
    add("dec10",      0, 0, 0, 0, '0, 0, 1, 10, 1, 1, 0, 0, 1, k128(0));
    add("dec11_rej",  0, 0, 0, 0, '0, 0, 1, 11, 1, 0, 1, 0, 1, '0);
    add("start_odd",  1, 5, 0, 0, '0, 0, 0, 0, 0,  0, 0, 0, 0, '0);
    for (int i = 0; i < 15; i++)
      add("wr_odd",   0, 0, 1, 4'(i), kalt(i), 0, 0, 0, 0, 0, 0, 0, 0, '0);
    add("done_odd",   0, 0, 0, 0, '0, 1, 0, 0, 0,  0, 0, 0, 1, '0);
    add("rd14_odd",   0, 0, 0, 0, '0, 0, 1, 14, 0, 1, 0, 0, 1, kalt(14));
    add("start_short",1, 14, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 11; i++)
      add("wr_short", 0, 0, 1, 4'(i), k256(i), 0, 0, 0, 0, 0, 0, 0, 0, '0);
    add("done_short", 0, 0, 0, 0, '0, 1, 0, 0, 0,  0, 0, 1, 0, '0);
    add("rd_empty",   0, 0, 0, 0, '0, 0, 1, 0, 0,  0, 1, 0, 0, '0);
    add("idle_end",   0, 0, 0, 0, '0, 0, 0, 0, 0,  0, 0, 0, 0, '0);
  endtask

  task automatic run_table();
    build_table();
    foreach (tbl[i]) begin
      bus.exp_start = tbl[i].es; bus.rounds_total = tbl[i].rt;
      bus.wr_en = tbl[i].we; bus.wr_addr = tbl[i].wa; bus.wr_data = tbl[i].wd;
      bus.wr_done = tbl[i].wdn; bus.rd_en = tbl[i].re; bus.rd_addr = tbl[i].ra;
      bus.decrypt = tbl[i].dec;
      tick(tbl[i].nm);
      chk_outs(tbl[i].nm, tbl[i].ed, tbl[i].ev, tbl[i].ee, tbl[i].el, tbl[i].er);
    end
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_outs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic reset_test();
    bus.exp_start = 1'b1; bus.rounds_total = 4'd10; tick("rl_start"); idle();
    for (int i = 0; i < 11; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = k128(i + 32); tick("rl_wr"); idle();
    end
    bus.wr_done = 1'b1; tick("rl_done"); idle();
    bus.exp_start = 1'b1; bus.rounds_total = 4'd10; bus.rd_en = 1'b1; bus.rd_addr = 4'd1;
    tick("rl_restart_rd"); idle();
    chk_outs("rl_restart_rd", k128(33), 1'b1, 1'b0, 1'b0, 1'b0);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = k128(7); tick("rl_midload"); idle();
    #2 reset_n = 1'b0;
    #1 chk_outs("async_rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    chk_outs("async_rst_hold", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    bus.rd_en = 1'b1; bus.rd_addr = 4'd0; tick("after_rst_rd"); idle();
    chk_outs("after_rst_rd", '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rnd_read();
    bus.rd_en   = 1'($urandom_range(0, 1));
    bus.rd_addr = 4'($urandom_range(0, 15));
    bus.decrypt = 1'($urandom_range(0, 1));
  endtask

  task automatic random_test();
    for (int ep = 0; ep < 40; ep++) begin
      logic [3:0] rt;
      int r, nw;
      case ($urandom_range(0, 3))
        0:       rt = 4'd10;
        1:       rt = 4'd14;
        default: rt = 4'($urandom_range(0, 15));
      endcase
      r  = (rt == 4'd10) ? 10 : 14;
      nw = ($urandom_range(0, 3) != 0) ? r + 1 : int'($urandom_range(0, 16));
      bus.exp_start = 1'b1; bus.rounds_total = rt; rnd_read(); tick("rnd_start"); idle();
      for (int i = 0; i < nw; i++) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(i);
        bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 19) == 0) bus.wr_done = 1'b1;
        rnd_read(); tick("rnd_wr"); idle();
      end
      bus.wr_done = 1'b1; rnd_read(); tick("rnd_done"); idle();
      repeat ($urandom_range(1, 8)) begin rnd_read(); tick("rnd_rd"); idle(); end
    end
  endtask

  task automatic dbuf_test();
    bus.exp_start = 1'b1; bus.rounds_total = 4'd10; tick_raw(); idle();
    for (int i = 0; i < 11; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = k128(i); tick_raw(); idle();
    end
    bus.wr_done = 1'b1; tick_raw(); idle();
    chk("db_ready_a", 128'(bus.keys_ready), 128'(1));
    bus.exp_start = 1'b1; bus.rounds_total = 4'd14; bus.rd_en = 1'b1; bus.rd_addr = 4'd3;
    tick_raw();
    chk_outs("db_start_b", k128(3), 1'b1, 1'b0, 1'b0, 1'b1);
    bus.exp_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = k256(i);
      tick_raw();
      chk_outs("db_load_b", k128(3), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    bus.wr_en = 1'b0; bus.wr_done = 1'b1;
    tick_raw();
    chk_outs("db_done_b", k128(3), 1'b1, 1'b0, 1'b0, 1'b1);
    bus.wr_done = 1'b0;
    tick_raw();
    chk_outs("db_read_b", k256(3), 1'b1, 1'b0, 1'b0, 1'b1);
    bus.exp_start = 1'b1; bus.rounds_total = 4'd10; tick_raw(); bus.exp_start = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = k128(99); tick_raw(); bus.wr_en = 1'b0;
    bus.wr_done = 1'b1; tick_raw(); bus.wr_done = 1'b0;
    chk_outs("db_bad_c", k256(3), 1'b1, 1'b0, 1'b1, 1'b1);
    tick_raw();
    chk_outs("db_after_bad", k256(3), 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    do_reset();
`ifdef ROUND_KEY_STORE_DBUF_EN
    dbuf_test();
`else
    run_table();
    reset_test();
    random_test();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
